// File: rtl/counter_unit.sv
// counter_unit: loadable free-running up-counter with a registered snapshot
// readout and a live combinational debug view of the count register.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | count holds; waiting for a start pulse
// RUN   | count increments every edge (modulo 2^xLen) until init/reset
module counter_unit #(
    parameter int xLen = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [xLen-1:0] init_val,
    input  logic            init,
    input  logic            start,
    input  logic            return_current_count,
    output logic [xLen-1:0] current_count,
    output logic [xLen-1:0] debug_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [xLen-1:0] count_q;
    logic [xLen-1:0] count_d;
    logic [xLen-1:0] snap_q;

    // State, count and snapshot registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            // Snapshot takes the pre-edge count, independent of state or init.
            if (return_current_count) begin
                snap_q <= count_q;
            end
        end
    end

    // Next-state and next-count: init beats start/run, which beats hold.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (init) begin
            // A start on the same edge is deliberately dropped.
            count_d = init_val;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // Entering RUN does not bump the count; the first
                    // increment lands on the following edge.
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // Natural wrap at all-ones; no overflow flag, no stop.
                    count_d = count_q + 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign current_count = snap_q;
    assign debug_out     = count_q;

endmodule

// File: tb/tb_counter_unit.sv
// Self-checking bench for counter_unit: directed scenarios plus a randomized
// run compared against a behavioural model of the counter.
module tb_counter_unit;

    localparam int XLEN = 64;

    logic            clk;
    logic            reset;
    logic [XLEN-1:0] init_val;
    logic            init;
    logic            start;
    logic            return_current_count;
    logic [XLEN-1:0] current_count;
    logic [XLEN-1:0] debug_out;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a count value, a running flag and a snapshot.
    logic [XLEN-1:0] m_count;
    bit              m_running;
    logic [XLEN-1:0] m_snap;

    counter_unit #(.xLen(XLEN)) dut (
        .clk                  (clk),
        .reset                (reset),
        .init_val             (init_val),
        .init                 (init),
        .start                (start),
        .return_current_count (return_current_count),
        .current_count        (current_count),
        .debug_out            (debug_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, update the model from the inputs sampled at
    // that edge, and return on the following falling edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            m_count   = '0;
            m_running = 1'b0;
            m_snap    = '0;
        end else begin
            if (return_current_count) m_snap = m_count;
            if (init) begin
                m_count   = init_val;
                m_running = 1'b0;
            end else if (m_running) begin
                m_count = m_count + 64'd1;
            end else if (start) begin
                m_running = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset                = 1'b1;
        init                 = 1'b0;
        start                = 1'b0;
        return_current_count = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        checks++;
        if (debug_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_debug got %0h exp 0", debug_out);
        end
        checks++;
        if (current_count !== 64'd0) begin
            errors++;
            $display("FAIL reset_cc got %0h exp 0", current_count);
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (debug_out !== 64'd0 || current_count !== 64'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got dbg %0h cc %0h exp 0 0",
                         i, debug_out, current_count);
            end
        end
    endtask

    task automatic test_load();
        idle_inputs();
        init     = 1'b1;
        init_val = 64'd75;
        tick();
        init = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (debug_out !== 64'd75 || current_count !== 64'd0) begin
                errors++;
                $display("FAIL load_hold cyc %0d got dbg %0d cc %0d exp 75 0",
                         i, debug_out, current_count);
            end
        end
    endtask

    task automatic test_count_snapshot();
        idle_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (debug_out !== 64'd75) begin
            errors++;
            $display("FAIL start_edge got %0d exp 75", debug_out);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (debug_out !== 64'd75 + 64'(k)) begin
                errors++;
                $display("FAIL count_step k %0d got %0d exp %0d",
                         k, debug_out, 75 + k);
            end
        end
        return_current_count = 1'b1;
        tick();
        return_current_count = 1'b0;
        checks++;
        if (current_count !== 64'd85) begin
            errors++;
            $display("FAIL snapshot got %0d exp 85", current_count);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (current_count !== 64'd85 || debug_out !== 64'd89) begin
            errors++;
            $display("FAIL snapshot_hold got cc %0d dbg %0d exp 85 89",
                     current_count, debug_out);
        end
    endtask

    task automatic test_wrap();
        logic [XLEN-1:0] exp_seq [4];
        exp_seq[0] = '1;
        exp_seq[1] = 64'd0;
        exp_seq[2] = 64'd1;
        exp_seq[3] = 64'd2;
        idle_inputs();
        init     = 1'b1;
        init_val = {{(XLEN-1){1'b1}}, 1'b0};
        tick();
        init  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (debug_out !== exp_seq[i]) begin
                errors++;
                $display("FAIL wrap step %0d got %0h exp %0h",
                         i, debug_out, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reload();
        idle_inputs();
        init     = 1'b1;
        init_val = 64'd97;
        tick();
        init  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (debug_out !== 64'd100) begin
            errors++;
            $display("FAIL reload_pre got %0d exp 100", debug_out);
        end
        init     = 1'b1;
        init_val = 64'd5;
        tick();
        init = 1'b0;
        tick();
        checks++;
        if (debug_out !== 64'd5) begin
            errors++;
            $display("FAIL reload_stop got %0d exp 5", debug_out);
        end
        init  = 1'b1;
        start = 1'b1;
        tick();
        init  = 1'b0;
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (debug_out !== 64'd5) begin
            errors++;
            $display("FAIL init_start_same_edge got %0d exp 5", debug_out);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (debug_out !== 64'd5 + 64'(k)) begin
                errors++;
                $display("FAIL resume k %0d got %0d exp %0d", k, debug_out, 5 + k);
            end
        end
    endtask

    task automatic test_reset_midrun();
        idle_inputs();
        init     = 1'b1;
        init_val = 64'd75;
        tick();
        init  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        return_current_count = 1'b1;
        tick();
        return_current_count = 1'b0;
        checks++;
        if (current_count !== 64'd85) begin
            errors++;
            $display("FAIL midrun_snap got %0d exp 85", current_count);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (debug_out !== 64'd0 || current_count !== 64'd0) begin
            errors++;
            $display("FAIL midrun_reset got dbg %0d cc %0d exp 0 0",
                     debug_out, current_count);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (debug_out !== 64'd0) begin
            errors++;
            $display("FAIL post_reset_idle got %0d exp 0", debug_out);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            reset                = ($urandom_range(0, 49) != 0);
            init                 = ($urandom_range(0, 9) == 0);
            start                = ($urandom_range(0, 5) == 0);
            return_current_count = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0)
                init_val = {{(XLEN-4){1'b1}}, 4'($urandom_range(0, 15))};
            else
                init_val = {$urandom(), $urandom()};
            tick();
            checks++;
            if (debug_out !== m_count || current_count !== m_snap) begin
                errors++;
                $display("FAIL random cyc %0d got dbg %0h cc %0h exp %0h %0h",
                         i, debug_out, current_count, m_count, m_snap);
            end
        end
    endtask

    initial begin
        m_count   = '0;
        m_running = 1'b0;
        m_snap    = '0;
        init_val  = '0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_load();
        test_count_snapshot();
        test_wrap();
        test_reload();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
